// File: rtl/c_fetch_pkg.sv
// Shared types and sizing helpers for the compressed-extension fetch controller.
package c_fetch_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT   = 32'h0000_0000;
  localparam int          FIFO_DEPTH_DEFAULT = 4;
  localparam int          MAX_OUTST_DEFAULT  = 2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
  } fetch_entry_t;

  // Width needed to hold any count from 0 up to and including max_val.
  function automatic int cnt_width(input int max_val);
    return $clog2(max_val + 1);
  endfunction

  localparam int FIFO_CNT_W  = cnt_width(FIFO_DEPTH_DEFAULT);
  localparam int OUTST_CNT_W = cnt_width(MAX_OUTST_DEFAULT);

endpackage

// File: rtl/c_fetch_fifo.sv
// In-order buffer of fetched words and their PCs; head is read straight from storage.
module c_fetch_fifo
  import c_fetch_pkg::*;
#(
  parameter int  DEPTH = FIFO_DEPTH_DEFAULT,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = cnt_width(DEPTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push,
  input  fetch_entry_t       push_data,
  input  logic               pop,
  input  logic               flush,
  output logic [CNT_W-1:0]   count,
  output fetch_entry_t       head
);

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // Flush outranks push and pop so a redirect never leaves stale words behind.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/c_fetch_ctrl.sv
// Fetch producer for the realigner: issues word fetches, buffers responses,
// and handles branch redirects with discard of in-flight responses.
module c_fetch_ctrl
  import c_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int          FIFO_DEPTH = FIFO_DEPTH_DEFAULT,
  parameter int          MAX_OUTST  = MAX_OUTST_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        branch_taken_i,
  input  logic [31:0] branch_target_i,
  input  logic        stall_pc_i,
  output logic        inst_valid_o,
  output logic [31:0] inst_o,
  output logic [31:0] pc_o,
  output logic        sel_for_branch_o,
  output logic        start_upper_o
);

  localparam int CNT_W = cnt_width(FIFO_DEPTH);
  localparam int OUT_W = cnt_width(MAX_OUTST);
  localparam int SUM_W = ((CNT_W > OUT_W) ? CNT_W : OUT_W) + 1;

  logic              active;
  logic [31:0]       fpc;
  logic [31:0]       pc_tag;
  logic [OUT_W-1:0]  outstanding;
  logic [OUT_W-1:0]  discard;
  logic [OUT_W-1:0]  outst_next;
  logic              pend_sel;
  logic              pend_upper;
  logic [CNT_W-1:0]  fifo_count;
  logic [SUM_W-1:0]  in_flight;
  logic              has_room;
  logic              issue;
  logic              push;
  logic              pop;
  logic [31:0]       target_word;
  logic              target_unused;
  fetch_entry_t      head;
  fetch_entry_t      push_data;

  // Slots are reserved at issue time, so a response can always be pushed.
  assign in_flight   = SUM_W'(fifo_count) + SUM_W'(outstanding);
  assign has_room    = (outstanding < OUT_W'(MAX_OUTST)) && (in_flight < SUM_W'(FIFO_DEPTH));
  assign imem_req_o  = active && has_room && !branch_taken_i;
  assign imem_addr_o = fpc;
  assign issue       = imem_req_o && imem_gnt_i;
  assign outst_next  = outstanding + OUT_W'(issue) - OUT_W'(imem_rvalid_i);

  assign target_word   = {branch_target_i[31:2], 2'b00};
  assign target_unused = branch_target_i[0];

  assign push      = imem_rvalid_i && (discard == '0) && !branch_taken_i;
  assign pop       = inst_valid_o && !stall_pc_i && !branch_taken_i;
  assign push_data = '{pc: pc_tag, word: imem_rdata_i};

  c_fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .flush     (branch_taken_i),
    .count     (fifo_count),
    .head      (head)
  );

  assign inst_valid_o     = (fifo_count != '0);
  assign inst_o           = head.word;
  assign pc_o             = head.pc;
  assign sel_for_branch_o = pend_sel && inst_valid_o;
  assign start_upper_o    = pend_upper && sel_for_branch_o;

  // On redirect every response still owed by memory is stale, so discard
  // simply becomes the post-cycle outstanding count; back-to-back redirects
  // therefore never double count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      active      <= 1'b0;
      fpc         <= RESET_PC;
      pc_tag      <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
      pend_sel    <= 1'b0;
      pend_upper  <= 1'b0;
    end else begin
      active      <= 1'b1;
      outstanding <= outst_next;
      if (branch_taken_i) begin
        fpc        <= target_word;
        pc_tag     <= target_word;
        discard    <= outst_next;
        pend_sel   <= 1'b1;
        pend_upper <= branch_target_i[1];
      end else begin
        if (issue) fpc <= fpc + 32'd4;
        if (imem_rvalid_i) begin
          if (discard != '0) discard <= discard - OUT_W'(1);
          else               pc_tag  <= pc_tag + 32'd4;
        end
        if (pop) pend_sel <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_c_fetch_ctrl.sv
// Directed bench for c_fetch_ctrl with an in-order instruction memory of adjustable latency.
module tb_c_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        branch_taken_i;
  logic [31:0] branch_target_i;
  logic        stall_pc_i;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [31:0] pc_o;
  logic        sel_for_branch_o;
  logic        start_upper_o;

  int checks = 0;
  int errors = 0;

  int          mem_lat = 1;
  logic        gnt_en  = 1'b1;
  logic [31:0] q_addr[$];
  int          q_stamp[$];
  int          cyc = 0;

  c_fetch_ctrl #(
    .RESET_PC   (32'h0000_0000),
    .FIFO_DEPTH (4),
    .MAX_OUTST  (2)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .imem_req_o       (imem_req_o),
    .imem_addr_o      (imem_addr_o),
    .imem_gnt_i       (imem_gnt_i),
    .imem_rvalid_i    (imem_rvalid_i),
    .imem_rdata_i     (imem_rdata_i),
    .branch_taken_i   (branch_taken_i),
    .branch_target_i  (branch_target_i),
    .stall_pc_i       (stall_pc_i),
    .inst_valid_o     (inst_valid_o),
    .inst_o           (inst_o),
    .pc_o             (pc_o),
    .sel_for_branch_o (sel_for_branch_o),
    .start_upper_o    (start_upper_o)
  );

  always #5 clk = ~clk;
  assign imem_gnt_i = gnt_en;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h006f_0089;
      32'h0000_0004: return 32'h2023_0040;
      default:       return 32'hA500_0000 | a;
    endcase
  endfunction

  // In-order memory: grants seen at an edge respond mem_lat cycles later.
  initial begin
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = 32'h0;
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) begin
        q_addr.delete();
        q_stamp.delete();
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = 32'h0;
      end else begin
        cyc++;
        if (imem_req_o && imem_gnt_i) begin
          q_addr.push_back(imem_addr_o);
          q_stamp.push_back(cyc);
        end
        #1;
        imem_rvalid_i = 1'b0;
        if (reset && q_addr.size() > 0 && (cyc - q_stamp[0] + 1) >= mem_lat) begin
          imem_rvalid_i = 1'b1;
          imem_rdata_i  = mem_word(q_addr[0]);
          void'(q_addr.pop_front());
          void'(q_stamp.pop_front());
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    reset           = 1'b0;
    branch_taken_i  = 1'b0;
    branch_target_i = 32'h0;
    stall_pc_i      = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic wait_valid(output logic found);
    for (int i = 0; i < 40; i++) begin
      if (inst_valid_o === 1'b1) break;
      step();
    end
    found = inst_valid_o;
  endtask

  task automatic test_reset();
    reset           = 1'b1;
    branch_taken_i  = 1'b0;
    branch_target_i = 32'h0;
    stall_pc_i      = 1'b0;
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    checks++; if (imem_req_o !== 1'b0) begin errors++; $display("[TB] FAIL rst_req got %b want 0", imem_req_o); end
    checks++; if (inst_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL rst_valid got %b want 0", inst_valid_o); end
    checks++; if (inst_o !== 32'h0) begin errors++; $display("[TB] FAIL rst_inst got %h want 0", inst_o); end
    checks++; if (pc_o !== 32'h0) begin errors++; $display("[TB] FAIL rst_pc got %h want 0", pc_o); end
    checks++; if (sel_for_branch_o !== 1'b0 || start_upper_o !== 1'b0) begin errors++; $display("[TB] FAIL rst_flags got %b%b want 00", sel_for_branch_o, start_upper_o); end
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++; if (imem_req_o !== 1'b0) begin errors++; $display("[TB] FAIL rst_release_req got %b want 0", imem_req_o); end
  endtask

  task automatic test_basic();
    step();
    checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin errors++; $display("[TB] FAIL basic_addr0 got req=%b addr=%h want req=1 addr=0", imem_req_o, imem_addr_o); end
    step();
    checks++; if (imem_addr_o !== 32'h4 || inst_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL basic_addr4 got addr=%h valid=%b want 4/0", imem_addr_o, inst_valid_o); end
    step();
    checks++; if (imem_addr_o !== 32'h8) begin errors++; $display("[TB] FAIL basic_addr8 got %h want 8", imem_addr_o); end
    checks++; if (inst_valid_o !== 1'b1 || inst_o !== 32'h006f0089 || pc_o !== 32'h0) begin errors++; $display("[TB] FAIL basic_word0 got v=%b inst=%h pc=%h want 1/006f0089/0", inst_valid_o, inst_o, pc_o); end
    checks++; if (sel_for_branch_o !== 1'b0) begin errors++; $display("[TB] FAIL basic_sel got %b want 0", sel_for_branch_o); end
    step();
    checks++; if (inst_o !== 32'h20230040 || pc_o !== 32'h4) begin errors++; $display("[TB] FAIL basic_word1 got inst=%h pc=%h want 20230040/4", inst_o, pc_o); end
    checks++; if (imem_addr_o !== 32'hC) begin errors++; $display("[TB] FAIL basic_addr12 got %h want c", imem_addr_o); end
  endtask

  task automatic test_stall();
    logic [31:0] exp_pc[4];
    exp_pc = '{32'h8, 32'hC, 32'h10, 32'h14};
    stall_pc_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (inst_valid_o !== 1'b1 || inst_o !== 32'h20230040 || pc_o !== 32'h4) begin errors++; $display("[TB] FAIL stall_hold%0d got v=%b inst=%h pc=%h want 1/20230040/4", i, inst_valid_o, inst_o, pc_o); end
    end
    checks++; if (imem_req_o !== 1'b0) begin errors++; $display("[TB] FAIL stall_full_req got %b want 0", imem_req_o); end
    stall_pc_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++; if (inst_valid_o !== 1'b1 || pc_o !== exp_pc[i] || inst_o !== (32'hA500_0000 | exp_pc[i])) begin errors++; $display("[TB] FAIL stall_drain%0d got v=%b pc=%h inst=%h want pc=%h", i, inst_valid_o, pc_o, inst_o, exp_pc[i]); end
    end
  endtask

  task automatic test_branch();
    logic found;
    mem_lat = 3;
    do_reset();
    repeat (3) step();
    branch_taken_i  = 1'b1;
    branch_target_i = 32'h0000_0102;
    step();
    branch_taken_i = 1'b0;
    checks++; if (imem_addr_o !== 32'h100) begin errors++; $display("[TB] FAIL branch_addr got %h want 100", imem_addr_o); end
    wait_valid(found);
    checks++; if (found !== 1'b1) begin errors++; $display("[TB] FAIL branch_timeout got valid=%b want 1", found); end
    checks++; if (pc_o !== 32'h100 || inst_o !== 32'hA500_0100) begin errors++; $display("[TB] FAIL branch_word got pc=%h inst=%h want 100/a5000100", pc_o, inst_o); end
    checks++; if (sel_for_branch_o !== 1'b1 || start_upper_o !== 1'b1) begin errors++; $display("[TB] FAIL branch_flags got %b%b want 11", sel_for_branch_o, start_upper_o); end
    step();
    checks++; if (sel_for_branch_o !== 1'b0) begin errors++; $display("[TB] FAIL branch_sel_clear got %b want 0", sel_for_branch_o); end
  endtask

  task automatic test_same_cycle();
    logic found;
    mem_lat = 1;
    do_reset();
    repeat (3) step();
    branch_taken_i  = 1'b1;
    branch_target_i = 32'h0000_0040;
    #1;
    checks++; if (imem_req_o !== 1'b0) begin errors++; $display("[TB] FAIL same_req_forced got %b want 0", imem_req_o); end
    step();
    branch_taken_i = 1'b0;
    checks++; if (inst_valid_o !== 1'b0 || imem_addr_o !== 32'h40) begin errors++; $display("[TB] FAIL same_flush got v=%b addr=%h want 0/40", inst_valid_o, imem_addr_o); end
    wait_valid(found);
    checks++; if (found !== 1'b1 || pc_o !== 32'h40 || inst_o !== 32'hA500_0040) begin errors++; $display("[TB] FAIL same_word got v=%b pc=%h inst=%h want 1/40/a5000040", found, pc_o, inst_o); end
    checks++; if (sel_for_branch_o !== 1'b1 || start_upper_o !== 1'b0) begin errors++; $display("[TB] FAIL same_flags got %b%b want 10", sel_for_branch_o, start_upper_o); end
  endtask

  task automatic test_redirect_stall();
    logic found;
    stall_pc_i = 1'b1;
    repeat (3) step();
    checks++; if (inst_valid_o !== 1'b1 || pc_o !== 32'h40 || sel_for_branch_o !== 1'b1) begin errors++; $display("[TB] FAIL rstall_hold got v=%b pc=%h sel=%b want 1/40/1", inst_valid_o, pc_o, sel_for_branch_o); end
    branch_taken_i  = 1'b1;
    branch_target_i = 32'h0000_0082;
    step();
    branch_taken_i = 1'b0;
    checks++; if (inst_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL rstall_flush got %b want 0", inst_valid_o); end
    wait_valid(found);
    checks++; if (found !== 1'b1 || pc_o !== 32'h80 || sel_for_branch_o !== 1'b1 || start_upper_o !== 1'b1) begin errors++; $display("[TB] FAIL rstall_word got v=%b pc=%h flags=%b%b want 1/80/11", found, pc_o, sel_for_branch_o, start_upper_o); end
    repeat (2) step();
    checks++; if (pc_o !== 32'h80 || sel_for_branch_o !== 1'b1) begin errors++; $display("[TB] FAIL rstall_sticky got pc=%h sel=%b want 80/1", pc_o, sel_for_branch_o); end
    stall_pc_i = 1'b0;
    step();
    checks++; if (inst_valid_o !== 1'b1 || pc_o !== 32'h84 || sel_for_branch_o !== 1'b0) begin errors++; $display("[TB] FAIL rstall_pop got v=%b pc=%h sel=%b want 1/84/0", inst_valid_o, pc_o, sel_for_branch_o); end
  endtask

  task automatic test_back_to_back();
    logic found;
    mem_lat = 3;
    do_reset();
    repeat (3) step();
    branch_taken_i  = 1'b1;
    branch_target_i = 32'h0000_0200;
    step();
    branch_target_i = 32'h0000_0302;
    step();
    branch_taken_i = 1'b0;
    wait_valid(found);
    checks++; if (found !== 1'b1 || pc_o !== 32'h300 || inst_o !== 32'hA500_0300) begin errors++; $display("[TB] FAIL b2b_word got v=%b pc=%h inst=%h want 1/300/a5000300", found, pc_o, inst_o); end
    checks++; if (sel_for_branch_o !== 1'b1 || start_upper_o !== 1'b1) begin errors++; $display("[TB] FAIL b2b_flags got %b%b want 11", sel_for_branch_o, start_upper_o); end
  endtask

  task automatic test_reset_mid();
    logic found;
    mem_lat = 3;
    do_reset();
    stall_pc_i = 1'b1;
    wait_valid(found);
    repeat (2) step();
    checks++; if (found !== 1'b1 || inst_o !== 32'h006f0089) begin errors++; $display("[TB] FAIL rmid_pre got v=%b inst=%h want 1/006f0089", found, inst_o); end
    #1 reset = 1'b0;
    #1;
    checks++; if (imem_req_o !== 1'b0 || inst_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL rmid_ctl got req=%b v=%b want 0/0", imem_req_o, inst_valid_o); end
    checks++; if (inst_o !== 32'h0 || pc_o !== 32'h0) begin errors++; $display("[TB] FAIL rmid_data got inst=%h pc=%h want 0/0", inst_o, pc_o); end
    checks++; if (sel_for_branch_o !== 1'b0 || start_upper_o !== 1'b0) begin errors++; $display("[TB] FAIL rmid_flags got %b%b want 00", sel_for_branch_o, start_upper_o); end
    mem_lat = 1;
    @(negedge clk);
    reset = 1'b1;
    step();
    checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin errors++; $display("[TB] FAIL rmid_restart got req=%b addr=%h want 1/0", imem_req_o, imem_addr_o); end
    repeat (2) step();
    checks++; if (inst_valid_o !== 1'b1 || inst_o !== 32'h006f0089 || pc_o !== 32'h0) begin errors++; $display("[TB] FAIL rmid_word got v=%b inst=%h pc=%h want 1/006f0089/0", inst_valid_o, inst_o, pc_o); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_branch();
    test_same_cycle();
    test_redirect_stall();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

endmodule

// File: doc/c_fetch_ctrl.md
Name: c_fetch_ctrl

Overview:
- Fetch-side producer for the compressed-extension realigner.
- Issues word-aligned requests to instruction memory and buffers the returned words with their PCs in an in-order FIFO.
- Presents one 32-bit word per cycle to the realigner and holds it while the realigner raises stall_pc.
- On a taken branch it flushes in-flight words and redirects fetch. It then flags the first post-branch word with sel_for_branch and a halfword-start indication.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset; bits[1:0] must be 0.
- FIFO_DEPTH, 4, fetch buffer entries; power of two, minimum 2.
- MAX_OUTST, 2, maximum imem requests granted but not yet responded.

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-low reset
- imem_req_o  out  1  fetch request valid
- imem_addr_o  out  32  fetch address, always word-aligned
- imem_gnt_i  in  1  request accepted this cycle
- imem_rvalid_i  in  1  response valid; responses return in order, at least 1 cycle after grant
- imem_rdata_i  in  32  response word
- branch_taken_i  in  1  redirect pulse from execute
- branch_target_i  in  32  halfword-aligned target; bit0 ignored
- stall_pc_i  in  1  realigner holds the current word
- inst_valid_o  out  1  inst_o/pc_o valid
- inst_o  out  32  fetched word (FIFO head)
- pc_o  out  32  word address of inst_o
- sel_for_branch_o  out  1  inst_o is the first word after a redirect
- start_upper_o  out  1  with sel_for_branch_o: the instruction starts at inst_o[31:16]

Behaviour:
- Reset (async, reset=0) clears all state:
  - fpc=RESET_PC; FIFO empty; outstanding=0; discard=0.
  - imem_req_o=0, inst_valid_o=0, inst_o=0, pc_o=0, sel_for_branch_o=0, start_upper_o=0.
  - Reset mid-transaction abandons everything; late rvalids arriving after reset release are ignored only through the discard counter, which is 0, so the memory must also be reset.
- Request issue:
  - imem_req_o=1 when outstanding<MAX_OUTST and (fifo_count+outstanding)<FIFO_DEPTH and no redirect this cycle.
  - imem_addr_o=fpc.
  - On req&gnt: fpc+=4 (wraps at 2^32), outstanding+=1.
- Response:
  - On rvalid, outstanding-=1.
  - If discard>0: discard-=1 and the word is dropped.
  - Otherwise push {pc_tag, rdata}; pc_tag is a separate counter advanced by 4 per accepted response.
  - Push is never refused, because slots are reserved at issue.
- Output:
  - inst_valid_o = FIFO non-empty; inst_o and pc_o come from the head (registered, zero latency from storage).
  - Pop when inst_valid_o & !stall_pc_i.
  - stall_pc_i while empty has no effect.
  - Push and pop in the same cycle: count unchanged.
  - Full plus push cannot occur.
- Redirect (branch_taken_i=1), highest priority:
  - FIFO flushed and pop suppressed.
  - fpc and pc_tag are set to {target[31:2],2'b00}.
  - discard = outstanding after this cycle's grant/rvalid; a grant in the same cycle counts, an rvalid in the same cycle is dropped.
  - imem_req_o is forced 0 in the redirect cycle.
  - Sets pend_sel=1 and pend_upper=target[1].
- Branch flagging:
  - sel_for_branch_o = pend_sel & inst_valid_o; start_upper_o = pend_upper & sel_for_branch_o.
  - Both flags stay high through stalls; pend_sel clears on the pop of that word.
- Back-to-back redirects: the last one wins, and discard accumulates correctly.
- Latency: first inst_valid_o 1 cycle after the first rvalid; minimum 3 cycles from redirect to flagged word with single-cycle memory.

Decomposition:
- Package c_fetch_pkg holds:
  - RESET_PC default.
  - typedef fetch_entry_t {logic [31:0] pc; logic [31:0] word;}.
  - Counter-width localparams derived from FIFO_DEPTH and MAX_OUTST.
- Sub-module c_fetch_fifo: synchronous FIFO of fetch_entry_t with push, pop, flush, count and head outputs.
- Request and redirect logic stay in c_fetch_ctrl.

Test Plan:
- Reset, then a memory with gnt=1 and 1-cycle rvalid returning words 32'h006f0089, 32'h20230040:
  - imem_addr_o sequence is 0, 4, 8...
  - inst_o=006f0089 with pc_o=0, then 20230040 with pc_o=4.
  - sel_for_branch_o=0.
- stall_pc_i held 3 cycles while inst_o=20230040:
  - inst_o and pc_o stay stable.
  - FIFO fills to 4, then imem_req_o drops.
  - After stall release, words pop in order with none lost.
- branch_taken_i with target 32'h0000_0102 while 2 requests are outstanding:
  - Both stale responses are dropped.
  - Next imem_addr_o=0x100.
  - The first output word has pc_o=0x100, sel_for_branch_o=1, start_upper_o=1.
- Redirect to 32'h0000_0040 in the same cycle as gnt and rvalid:
  - The rvalid word is dropped and the granted response is discarded.
  - First valid pc_o=0x40 with start_upper_o=0.
- Redirect while stall_pc_i=1 and the branch-flagged word is pending:
  - FIFO flushed; the new flagged word appears.
  - sel_for_branch_o stays high until a pop without stall.
- Assert reset low mid-burst with 2 outstanding requests:
  - All outputs go to 0 immediately, asynchronously.
  - After release, imem_addr_o=RESET_PC.
